// File: rtl/multi_signal_debouncer.sv
// N-channel debouncer: synchronises async inputs, filters them against a shared sample tick,
// and emits a registered level plus press / release / long-press pulses per channel.
module multi_signal_debouncer #(
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter int unsigned DEBOUNCE_COUNT = 65_536,
  parameter int unsigned STABLE_SAMPLES = 4,
  parameter int unsigned HOLD_SAMPLES   = 256,
  parameter bit          IN_ACTIVE_LOW  = 1'b1,
  parameter bit          OUT_ACTIVE_LOW = 1'b0
) (
  input  logic                    sys_clk,
  input  logic                    n_reset,
  input  logic [NUM_CHANNELS-1:0] in_sig,
  output logic [NUM_CHANNELS-1:0] out_level,
  output logic [NUM_CHANNELS-1:0] out_press,
  output logic [NUM_CHANNELS-1:0] out_release,
  output logic [NUM_CHANNELS-1:0] out_hold
);

  localparam int unsigned N  = NUM_CHANNELS;
  localparam int unsigned PW = $clog2(DEBOUNCE_COUNT);
  localparam int unsigned AW = $clog2(STABLE_SAMPLES + 1);
  localparam int unsigned HW = $clog2(HOLD_SAMPLES + 1);

  localparam logic [PW-1:0] PRE_LAST   = PW'(DEBOUNCE_COUNT - 1);
  localparam logic [AW-1:0] AGREE_LAST = AW'(STABLE_SAMPLES - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_SAMPLES);
  localparam logic [N-1:0]  IN_IDLE    = IN_ACTIVE_LOW  ? {N{1'b1}} : {N{1'b0}};
  localparam logic [N-1:0]  OUT_IDLE   = OUT_ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};
  localparam logic [N-1:0]  OUT_XOR    = OUT_IDLE;

  logic [N-1:0]  sync1_q, sync2_q, sync3_q;
  logic [N-1:0]  act_c;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_c;

  logic [AW-1:0] agree_q [N];
  logic [AW-1:0] agree_d [N];
  logic [HW-1:0] hold_q  [N];
  logic [HW-1:0] hold_d  [N];
  logic [N-1:0]  stable_q, stable_d;
  logic [N-1:0]  press_d, release_d, hold_pulse_d;

  logic [N-1:0]  level_q, press_q, release_q, hold_pulse_q;

  // Three-stage synchroniser, reset to the idle input level.
  always_ff @(posedge sys_clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1_q <= IN_IDLE;
      sync2_q <= IN_IDLE;
      sync3_q <= IN_IDLE;
    end else begin
      sync1_q <= in_sig;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign act_c = IN_ACTIVE_LOW ? ~sync3_q : sync3_q;

  // Shared sample-tick prescaler.
  always_comb begin
    tick_c = (pre_q == PRE_LAST);
    pre_d  = tick_c ? '0 : pre_q + PW'(1);
  end

  // Per-channel agreement, stable level and hold tracking; all state moves only on tick.
  always_comb begin
    stable_d     = stable_q;
    press_d      = '0;
    release_d    = '0;
    hold_pulse_d = '0;
    for (int i = 0; i < int'(N); i++) begin
      agree_d[i] = agree_q[i];
      hold_d[i]  = hold_q[i];
      if (tick_c) begin
        if (act_c[i] == stable_q[i]) begin
          agree_d[i] = '0;
        end else if (agree_q[i] < AGREE_LAST) begin
          agree_d[i] = agree_q[i] + AW'(1);
        end else begin
          agree_d[i]  = '0;
          stable_d[i] = act_c[i];
          press_d[i]   = act_c[i];
          release_d[i] = ~act_c[i];
        end

        // A flip on this tick restarts hold counting, so release always wins over long-press.
        if (press_d[i] || release_d[i] || !stable_q[i]) begin
          hold_d[i] = '0;
        end else if (hold_q[i] != HOLD_MAX) begin
          hold_d[i] = hold_q[i] + HW'(1);
          hold_pulse_d[i] = (hold_d[i] == HOLD_MAX);
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge n_reset) begin
    if (!n_reset) begin
      pre_q    <= '0;
      stable_q <= '0;
      for (int i = 0; i < int'(N); i++) begin
        agree_q[i] <= '0;
        hold_q[i]  <= '0;
      end
    end else begin
      pre_q    <= pre_d;
      stable_q <= stable_d;
      for (int i = 0; i < int'(N); i++) begin
        agree_q[i] <= agree_d[i];
        hold_q[i]  <= hold_d[i];
      end
    end
  end

  // Output registers carry the final polarity so the ports are driven straight from flops.
  always_ff @(posedge sys_clk or negedge n_reset) begin
    if (!n_reset) begin
      level_q      <= OUT_IDLE;
      press_q      <= OUT_IDLE;
      release_q    <= OUT_IDLE;
      hold_pulse_q <= OUT_IDLE;
    end else begin
      level_q      <= stable_d     ^ OUT_XOR;
      press_q      <= press_d      ^ OUT_XOR;
      release_q    <= release_d    ^ OUT_XOR;
      hold_pulse_q <= hold_pulse_d ^ OUT_XOR;
    end
  end

  assign out_level   = level_q;
  assign out_press   = press_q;
  assign out_release = release_q;
  assign out_hold    = hold_pulse_q;

endmodule

// File: tb/tb_multi_signal_debouncer.sv
// Bench for multi_signal_debouncer: two instances with opposite polarities fed the same stimulus,
// checked every cycle against a tick-level behavioural model plus directed literal expectations.
module tb_multi_signal_debouncer;

  localparam int N  = 4;
  localparam int DC = 4;
  localparam int SS = 3;
  localparam int HS = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] in_sig = 4'hF;
  logic [N-1:0] in_sig_b;
  logic [N-1:0] lvl_a, prs_a, rel_a, hld_a;
  logic [N-1:0] lvl_b, prs_b, rel_b, hld_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign in_sig_b = ~in_sig;

  multi_signal_debouncer #(
    .NUM_CHANNELS(N), .DEBOUNCE_COUNT(DC), .STABLE_SAMPLES(SS), .HOLD_SAMPLES(HS),
    .IN_ACTIVE_LOW(1'b1), .OUT_ACTIVE_LOW(1'b0)
  ) dut_a (
    .sys_clk(clk), .n_reset(rst_n), .in_sig(in_sig),
    .out_level(lvl_a), .out_press(prs_a), .out_release(rel_a), .out_hold(hld_a)
  );

  multi_signal_debouncer #(
    .NUM_CHANNELS(N), .DEBOUNCE_COUNT(DC), .STABLE_SAMPLES(SS), .HOLD_SAMPLES(HS),
    .IN_ACTIVE_LOW(1'b0), .OUT_ACTIVE_LOW(1'b1)
  ) dut_b (
    .sys_clk(clk), .n_reset(rst_n), .in_sig(in_sig_b),
    .out_level(lvl_b), .out_press(prs_b), .out_release(rel_b), .out_hold(hld_b)
  );

  // Behavioural model: input seen 3 edges late, tick every DC edges, flip after SS disagreeing ticks,
  // long-press when HS ticks have elapsed since the press tick.
  logic [N-1:0] pipe [$];
  logic [N-1:0] m_raw, m_a, m_stable, m_press, m_rel, m_hold;
  int           m_run [N];
  int           m_ptick [N];
  bit           m_held [N];
  bit           m_flip;
  int           edge_n, tick_n;

  task automatic model_reset();
    pipe.delete();
    repeat (3) pipe.push_back(4'hF);
    m_stable = '0; m_press = '0; m_rel = '0; m_hold = '0;
    edge_n = 0; tick_n = 0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_ptick[i] = 0; m_held[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    m_raw = pipe.pop_front();
    pipe.push_back(in_sig);
    m_a = ~m_raw;
    m_press = '0; m_rel = '0; m_hold = '0;
    if (edge_n % DC == DC - 1) begin
      tick_n++;
      for (int i = 0; i < N; i++) begin
        m_flip = 1'b0;
        if (m_a[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == SS) begin
            m_stable[i] = m_a[i];
            m_run[i] = 0;
            m_flip = 1'b1;
            if (m_a[i]) begin
              m_press[i] = 1'b1; m_ptick[i] = tick_n; m_held[i] = 1'b0;
            end else begin
              m_rel[i] = 1'b1;
            end
          end
        end else begin
          m_run[i] = 0;
        end
        if (!m_flip && m_stable[i] && !m_held[i] && (tick_n - m_ptick[i] == HS)) begin
          m_hold[i] = 1'b1; m_held[i] = 1'b1;
        end
      end
    end
    edge_n++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare plus pulse counters used by the directed checks.
  int cnt_press [N];
  int cnt_rel [N];
  int cnt_hold [N];
  bit seen_allpress, seen_allrel;

  task automatic clr_cnt();
    for (int i = 0; i < N; i++) begin
      cnt_press[i] = 0; cnt_rel[i] = 0; cnt_hold[i] = 0;
    end
    seen_allpress = 1'b0; seen_allrel = 1'b0;
  endtask

  initial begin
    clr_cnt();
    forever begin
      @(posedge clk);
      #1;
      chk("level_a", lvl_a, m_stable);
      chk("press_a", prs_a, m_press);
      chk("release_a", rel_a, m_rel);
      chk("hold_a", hld_a, m_hold);
      chk("level_b", lvl_b, ~m_stable);
      chk("press_b", prs_b, ~m_press);
      chk("release_b", rel_b, ~m_rel);
      chk("hold_b", hld_b, ~m_hold);
      for (int i = 0; i < N; i++) begin
        cnt_press[i] += int'(prs_a[i]);
        cnt_rel[i]   += int'(rel_a[i]);
        cnt_hold[i]  += int'(hld_a[i]);
      end
      if (prs_a == 4'hF) seen_allpress = 1'b1;
      if (rel_a == 4'hF) seen_allrel = 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int sum_cnt(input int which);
    int s = 0;
    for (int i = 0; i < N; i++) begin
      if (which == 0) s += cnt_press[i];
      else if (which == 1) s += cnt_rel[i];
      else s += cnt_hold[i];
    end
    return s;
  endfunction

  int lat;

  initial begin
    in_sig = 4'hF;
    rst_n  = 1'b0;
    cyc(3);
    chk("rst_level_a", lvl_a, 4'h0);
    chk("rst_level_b", lvl_b, 4'hF);
    rst_n = 1'b1;

    // Idle inputs: nothing happens.
    clr_cnt();
    cyc(100);
    chk("t1_level", lvl_a, 4'h0);
    chk_int("t1_pulses", sum_cnt(0) + sum_cnt(1) + sum_cnt(2), 0);

    // Single press on ch0 within 16 cycles.
    clr_cnt();
    in_sig[0] = 1'b0;
    lat = 0;
    while (cnt_press[0] == 0 && lat < 40) begin
      cyc(1);
      lat++;
    end
    chk_int("t2_latency_le16", int'(lat <= 16), 1);
    cyc(2);
    chk_int("t2_press_once", cnt_press[0], 1);
    chk("t2_level_a", lvl_a, 4'h1);
    chk("t2_level_b", lvl_b, 4'hE);
    in_sig[0] = 1'b1;
    cyc(30);
    chk_int("t2_release_once", cnt_rel[0], 1);
    chk_int("t2_no_hold", cnt_hold[0], 0);

    // Short glitch on ch1 is filtered.
    clr_cnt();
    in_sig[1] = 1'b0;
    cyc(6);
    in_sig[1] = 1'b1;
    cyc(40);
    chk_int("t3_no_pulses", sum_cnt(0) + sum_cnt(1) + sum_cnt(2), 0);
    chk("t3_level", lvl_a, 4'h0);

    // Long press on ch2: one press, one hold, then one release.
    clr_cnt();
    in_sig[2] = 1'b0;
    cyc(60);
    chk_int("t4_press", cnt_press[2], 1);
    chk_int("t4_hold_once", cnt_hold[2], 1);
    in_sig[2] = 1'b1;
    cyc(30);
    chk_int("t4_release_once", cnt_rel[2], 1);
    chk_int("t4_hold_still_once", cnt_hold[2], 1);
    chk("t4_level", lvl_a, 4'h0);

    // All channels together, then release together.
    clr_cnt();
    in_sig = 4'h0;
    cyc(30);
    chk_int("t5_all_press_same_cycle", int'(seen_allpress), 1);
    in_sig = 4'hF;
    cyc(30);
    chk_int("t5_all_release_same_cycle", int'(seen_allrel), 1);

    // Bouncing ch3 never settles long enough to press.
    clr_cnt();
    repeat (14) begin
      in_sig[3] = 1'b0;
      cyc(2);
      in_sig[3] = 1'b1;
      cyc(4);
    end
    cyc(20);
    chk_int("t5_bounce_no_press", cnt_press[3], 0);
    chk("t5_bounce_level", lvl_a, 4'h0);

    // Reset with ch0 pressed and ch1 mid-count.
    in_sig = 4'hE;
    cyc(20);
    chk("t6_pre_level", lvl_a, 4'h1);
    in_sig[1] = 1'b0;
    lat = 0;
    while (m_run[1] != 2 && lat < 30) begin
      cyc(1);
      lat++;
    end
    chk_int("t6_reached_agree2", m_run[1], 2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_level_a", lvl_a, 4'h0);
    chk("t6_rst_press_a", prs_a | rel_a | hld_a, 4'h0);
    chk("t6_rst_level_b", lvl_b, 4'hF);
    cyc(3);
    in_sig = 4'hF;
    rst_n = 1'b1;
    clr_cnt();
    cyc(40);
    chk_int("t6_no_pulses_after", sum_cnt(0) + sum_cnt(1) + sum_cnt(2), 0);
    chk("t6_level_after", lvl_a, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
